// File: rtl/iom_bus_master.sv
// iom_bus_master: single-beat initiator for the 20-bit memory/IO bus.
// Turns one accepted request into an 8088-style T1/T2/T3/(Tw)/T4 cycle.
// Optional feature macro IOM_READY_EN: when defined, READY is sampled in T3/Tw
// to insert wait states, with a timeout abort after MAX_WAIT of them. When it
// is undefined, every cycle is a fixed four clocks and err stays low.
module iom_bus_master #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] Address,
    output logic              CS,
    output logic              ALE,
    output logic              RD,
    output logic              WR,
    output logic              IOM,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              READY
);

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                strobe;
    logic                to_t4;
    logic                we_l;
    logic                io_l;
    logic [ADDR_W-1:0]   addr_l;
    logic [DATA_W-1:0]   wdata_l;

`ifdef IOM_READY_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0]    wait_cnt;
    logic                err_l;
    logic                timeout;
`else
    localparam int unused_max_wait = MAX_WAIT;
    logic                unused_ready;
    assign unused_ready = READY;
`endif

    // Next-state selection and bus-signal decode from the current phase
    always_comb begin
        state_nxt = state;
        req_ready = (state == IDLE) || (state == T4);
        accept    = req && req_ready;
        busy      = (state != IDLE);
        strobe    = (state == T2) || (state == T3) || (state == TW);
        done      = (state == T4);
        CS        = busy;
        ALE       = (state == T1);
        RD        = !(strobe && !we_l);
        WR        = !(strobe && we_l);
        IOM       = busy ? io_l : 1'b0;
        Address   = busy ? addr_l : '0;
        Data_oe   = busy && we_l;
        Data_out  = (busy && we_l) ? wdata_l : '0;
        err       = 1'b0;
`ifdef IOM_READY_EN
        timeout   = !READY && (wait_cnt == CNT_W'(MAX_WAIT));
        err       = done && err_l;
`endif
        case (state)
            IDLE: if (accept) state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
`ifdef IOM_READY_EN
            T3:   state_nxt = READY ? T4 : TW;
            TW:   if (READY || timeout) state_nxt = T4;
`else
            T3:   state_nxt = T4;
            TW:   state_nxt = T4;
`endif
            T4:   state_nxt = accept ? T1 : IDLE;
            default: state_nxt = IDLE;
        endcase
        to_t4 = ((state == T3) || (state == TW)) && (state_nxt == T4);
    end

    // Phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request latch, loaded only on the accept edge so req_* may change freely otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_l    <= 1'b0;
            io_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
        end else if (accept) begin
            we_l    <= req_we;
            io_l    <= req_io;
            addr_l  <= req_addr;
            wdata_l <= req_wdata;
        end
    end

    // Read data capture on the edge into T4; held across writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 rdata <= '0;
        else if (to_t4 && !we_l) rdata <= Data_in;
    end

`ifdef IOM_READY_EN
    // Wait-state counter: counts each entry into Tw, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (accept)
            wait_cnt <= '0;
        else if ((state_nxt == TW) && (wait_cnt != CNT_W'(MAX_WAIT)))
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Timeout flag: set when the last permitted Tw still sees READY low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          err_l <= 1'b0;
        else if (accept)                  err_l <= 1'b0;
        else if ((state == TW) && timeout) err_l <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_iom_bus_master.sv
// tb_iom_bus_master: table-driven and randomized bench for iom_bus_master.
// Expected bus waveforms are derived from the cycle index within a bus cycle.
module tb_iom_bus_master;

    localparam int AW = 20;
    localparam int DW = 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, req_we, req_io;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, busy, done, err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] Address;
    logic          CS, ALE, RD, WR, IOM;
    logic [DW-1:0] Data_out;
    logic          Data_oe;
    logic [DW-1:0] Data_in;
    logic          READY;

    int            nvec = 0;
    int            nerr = 0;
    logic [DW-1:0] model_rdata;

    typedef struct {
        logic          we;
        logic          io;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] din;
        int            rlow;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t tbl[$];

    iom_bus_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .Address(Address),
        .CS(CS), .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .Data_out(Data_out),
        .Data_oe(Data_oe), .Data_in(Data_in), .READY(READY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle();
        chk("idle_busy", busy, 0);
        chk("idle_ready", req_ready, 1);
        chk("idle_cs", CS, 0);
        chk("idle_ale", ALE, 0);
        chk("idle_rd", RD, 1);
        chk("idle_wr", WR, 1);
        chk("idle_iom", IOM, 0);
        chk("idle_oe", Data_oe, 0);
        chk("idle_dout", Data_out, 0);
        chk("idle_addr", Address, 0);
        chk("idle_done", done, 0);
        chk("idle_err", err, 0);
        chk("idle_rdata", rdata, model_rdata);
    endtask

    // One complete bus cycle from IDLE; rlow = clocks READY is held low starting at T3
    task automatic run_txn(input logic we, input logic io, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] din, input int rlow,
                           input logic [DW-1:0] exp_rd, input logic exp_err);
        int nw;
        int len;
`ifdef IOM_READY_EN
        nw = (rlow > MW) ? MW : rlow;
`else
        nw = 0;
`endif
        len = 4 + nw;
        @(negedge clk);
        chk_idle();
        req = 1'b1; req_we = we; req_io = io; req_addr = addr; req_wdata = wd;
        READY = 1'b1; Data_in = DW'($urandom);
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk("busy", busy, 1);
            chk("cs", CS, 1);
            chk("ale", ALE, k == 1);
            chk("rd", RD, !(!we && k >= 2 && k <= len - 1));
            chk("wr", WR, !(we && k >= 2 && k <= len - 1));
            chk("iom", IOM, io);
            chk("addr", Address, addr);
            chk("oe", Data_oe, we);
            chk("dout", Data_out, we ? wd : 8'h00);
            chk("done", done, k == len);
            chk("req_ready", req_ready, k == len);
            chk("err", err, (k == len) ? exp_err : 1'b0);
            if (k == len) chk("rdata", rdata, exp_rd);
            req       = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we    = 1'($urandom);
            req_io    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
`ifdef IOM_READY_EN
            READY = (k >= 3 && k < 3 + rlow) ? 1'b0 : 1'b1;
`else
            READY = 1'($urandom);
`endif
            Data_in = (k == len - 1) ? din : DW'($urandom);
        end
        model_rdata = exp_rd;
    endtask

    initial begin
        logic [DW-1:0] wds [3];
        logic          we, io;
        logic [DW-1:0] din, erd;
        int            rl;
        logic          eerr;

        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_io = 1'b0; req_addr = '0;
        req_wdata = '0; Data_in = '0; READY = 1'b1; model_rdata = '0;
        #1;
        chk_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        tbl.push_back('{1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 0, 8'hA5, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 20'h003F8, 8'h5A, 8'h33, 0, 8'hA5, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 20'hFFFFF, 8'h00, 8'h00, 0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 20'h00000, 8'hFF, 8'h81, 0, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 20'h80000, 8'h00, 8'h3C, 0, 8'h3C, 1'b0});
`ifdef IOM_READY_EN
        tbl.push_back('{1'b0, 1'b0, 20'h54321, 8'h00, 8'hC3, 3,  8'hC3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 20'h00060, 8'h00, 8'h99, 40, 8'h99, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 20'h00061, 8'h44, 8'h12, 0,  8'h99, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 20'h00062, 8'h45, 8'h12, 15, 8'h99, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 20'h00063, 8'h00, 8'h6E, 16, 8'h6E, 1'b1});
`endif
        for (int i = 0; i < tbl.size(); i++)
            run_txn(tbl[i].we, tbl[i].io, tbl[i].addr, tbl[i].wd, tbl[i].din,
                    tbl[i].rlow, tbl[i].exp_rd, tbl[i].exp_err);

        // Back-to-back writes with req held high
        wds[0] = 8'h11; wds[1] = 8'h22; wds[2] = 8'h33;
        @(negedge clk);
        chk_idle();
        req = 1'b1; req_we = 1'b1; req_io = 1'b0; req_addr = 20'h00100; req_wdata = wds[0];
        READY = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            int ph;
            int idx;
            @(negedge clk);
            ph  = (k - 1) % 4;
            idx = (k - 1) / 4;
            chk("b2b_busy", busy, 1);
            chk("b2b_done", done, ph == 3);
            chk("b2b_ready", req_ready, ph == 3);
            chk("b2b_ale", ALE, ph == 0);
            chk("b2b_wr", WR, !(ph == 1 || ph == 2));
            chk("b2b_rd", RD, 1);
            chk("b2b_oe", Data_oe, 1);
            chk("b2b_dout", Data_out, wds[idx]);
            chk("b2b_addr", Address, 20'h00100 + 20'(idx));
            if (ph == 3) begin
                if (idx < 2) begin
                    req_wdata = wds[idx + 1];
                    req_addr  = 20'h00100 + 20'(idx + 1);
                end else begin
                    req = 1'b0;
                end
            end
        end

        // Asynchronous reset in T2 of a write
        @(negedge clk);
        chk_idle();
        req = 1'b1; req_we = 1'b1; req_io = 1'b1; req_addr = 20'h0ABCD; req_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("t2_wr", WR, 0);
        chk("t2_oe", Data_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wr", WR, 1);
        chk("rst_cs", CS, 0);
        chk("rst_oe", Data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_iom", IOM, 0);
        model_rdata = '0;
        @(negedge clk);
        chk("rst_hold_done", done, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        run_txn(1'b0, 1'b0, 20'h2468A, 8'h00, 8'hD7, 0, 8'hD7, 1'b0);

        // Randomized transactions against the cycle-index model
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom);
            io  = 1'($urandom);
            din = DW'($urandom);
            rl  = ($urandom_range(0, 7) == 0) ? 16 + $urandom_range(0, 4) : $urandom_range(0, 3);
`ifdef IOM_READY_EN
            eerr = (rl > MW);
`else
            eerr = 1'b0;
`endif
            erd = we ? model_rdata : din;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(we, io, AW'($urandom), DW'($urandom), din, rl, erd, eerr);
        end

        @(negedge clk);
        chk_idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
